// File: rtl/rr_mux_arbiter4.sv
// Round-robin arbiter that shares one 4:1 1-bit mux between four bit-serial sources.
// Optional owner tenure limit under contention is enabled by defining ARB_HOLD_LIMIT_EN.

module mux4x1 (
  input  logic [3:0] d_i,
  input  logic [1:0] s_i,
  output logic       y_o
);

  assign y_o = d_i[s_i];

endmodule

module rr_mux_arbiter4 #(
  parameter int unsigned HOLD_MAX = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic [3:0] in,
  output logic [3:0] gnt,
  output logic [1:0] sel,
  output logic       valid,
  output logic       y
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  if (HOLD_MAX < 2 || HOLD_MAX > 255) begin : g_bad_hold_max
    $error("rr_mux_arbiter4: HOLD_MAX must be in 2..255");
  end

  state_t     state_q;
  logic [3:0] gnt_q;
  logic [1:0] sel_q;
  logic [1:0] ptr_q;
  logic       valid_q;

  logic [3:0] cand_mask;
  logic       keep_owner;
  logic       win_found;
  logic [1:0] win_idx;
  logic       mux_y;

`ifdef ARB_HOLD_LIMIT_EN
  localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);
  logic [7:0] hold_cnt_q;
`endif

  // First set bit at or after p (ascending, mod 4); lowest offset wins.
  function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int k = 3; k >= 0; k--) begin
      idx = p + 2'(k);
      if (r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  always_comb begin
    cand_mask  = req;
    keep_owner = 1'b0;
    if (state_q == GRANT && req[sel_q]) begin
      keep_owner = 1'b1;
`ifdef ARB_HOLD_LIMIT_EN
      // Tenure exhausted and someone else waiting: hand over to the others only.
      if (hold_cnt_q == HOLD_LAST && (req & ~gnt_q) != 4'b0000) begin
        keep_owner = 1'b0;
        cand_mask  = req & ~gnt_q;
      end
`endif
    end
    {win_found, win_idx} = rr_pick(cand_mask, ptr_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      gnt_q      <= 4'b0000;
      sel_q      <= 2'd0;
      ptr_q      <= 2'd0;
      valid_q    <= 1'b0;
`ifdef ARB_HOLD_LIMIT_EN
      hold_cnt_q <= 8'd0;
`endif
    end else if (keep_owner) begin
`ifdef ARB_HOLD_LIMIT_EN
      if (hold_cnt_q != HOLD_LAST) hold_cnt_q <= hold_cnt_q + 8'd1;
`endif
    end else if (win_found) begin
      state_q    <= GRANT;
      gnt_q      <= 4'b0001 << win_idx;
      sel_q      <= win_idx;
      ptr_q      <= win_idx + 2'd1;
      valid_q    <= 1'b1;
`ifdef ARB_HOLD_LIMIT_EN
      hold_cnt_q <= 8'd0;
`endif
    end else begin
      // sel_q deliberately holds its last value while idle.
      state_q <= IDLE;
      gnt_q   <= 4'b0000;
      valid_q <= 1'b0;
    end
  end

  mux4x1 u_mux (
    .d_i (in),
    .s_i (sel_q),
    .y_o (mux_y)
  );

  assign gnt   = gnt_q;
  assign sel   = sel_q;
  assign valid = valid_q;
  assign y     = valid_q & mux_y;

endmodule

// File: tb/tb_rr_mux_arbiter4.sv
// Directed bench for rr_mux_arbiter4 (HOLD_MAX=4); expectations follow ARB_HOLD_LIMIT_EN if defined.

module tb_rr_mux_arbiter4;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic [3:0] din;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       valid;
  logic       y;

  int n_checks = 0;
  int n_errors = 0;

  rr_mux_arbiter4 #(.HOLD_MAX(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .in    (din),
    .gnt   (gnt),
    .sel   (sel),
    .valid (valid),
    .y     (y)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [3:0] eg, input logic [1:0] es,
                         input logic ev);
    chk({tag, ".gnt"}, gnt, eg);
    chk({tag, ".sel"}, {2'b00, sel}, {2'b00, es});
    chk({tag, ".valid"}, {3'b000, valid}, {3'b000, ev});
  endtask

  initial begin
    logic [3:0] exp_g;
    rst = 1'b1;
    req = 4'hF;
    din = 4'hF;
    #12;
    chk_out("reset", 4'b0000, 2'd0, 1'b0);
    chk("reset.y", {3'b000, y}, 4'b0000);

    rst = 1'b0;
    tick();
    chk_out("first_grant", 4'b0001, 2'd0, 1'b1);
    chk("first_grant.y", {3'b000, y}, 4'b0001);

    req = 4'b0000;
    tick();
    chk_out("to_idle", 4'b0000, 2'd0, 1'b0);

    req = 4'b0100;
    din = 4'b0100;
    tick();
    chk_out("single_req", 4'b0100, 2'd2, 1'b1);
    chk("single_req.y1", {3'b000, y}, 4'b0001);
    din = 4'b1011;
    #1;
    chk("single_req.y0", {3'b000, y}, 4'b0000);

    req = 4'b0000;
    din = 4'hF;
    tick();
    chk_out("idle_sel_hold", 4'b0000, 2'd2, 1'b0);
    chk("idle_sel_hold.y", {3'b000, y}, 4'b0000);

    // ptr is 3 after granting source 2
    req = 4'hF;
    tick();
    chk_out("ptr_after_2", 4'b1000, 2'd3, 1'b1);

    rst = 1'b1;
    #1;
    chk_out("async_rst", 4'b0000, 2'd0, 1'b0);
    chk("async_rst.y", {3'b000, y}, 4'b0000);
    tick();
    rst = 1'b0;

    req = 4'hF;
    tick();
    chk_out("rot0", 4'b0001, 2'd0, 1'b1);
    for (int k = 1; k <= 4; k++) begin
      req = 4'hF & ~(4'b0001 << ((k - 1) % 4));
      tick();
      exp_g = 4'b0001 << (k % 4);
      chk($sformatf("rot%0d", k), gnt, exp_g);
      chk($sformatf("rot%0d.valid", k), {3'b000, valid}, 4'b0001);
    end

    req = 4'b0010;
    tick();
    chk_out("handoff_a", 4'b0010, 2'd1, 1'b1);
    req = 4'b1000;
    tick();
    chk_out("handoff_b", 4'b1000, 2'd3, 1'b1);
    req = 4'b0000;
    tick();
    chk_out("handoff_idle", 4'b0000, 2'd3, 1'b0);

    req = 4'b1001;
    tick();
    chk_out("rerequest", 4'b0001, 2'd0, 1'b1);

    rst = 1'b1;
    #1;
    tick();
    rst = 1'b0;
    req = 4'b0011;
    for (int t = 0; t < 12; t++) begin
      tick();
`ifdef ARB_HOLD_LIMIT_EN
      exp_g = ((t / 4) % 2 == 1) ? 4'b0010 : 4'b0001;
`else
      exp_g = 4'b0001;
`endif
      chk($sformatf("hold_t%0d", t), gnt, exp_g);
      if (t == 11) req = 4'b0001;
    end

    for (int t = 0; t < 4; t++) begin
      tick();
      chk($sformatf("sat_t%0d", t), gnt, 4'b0001);
    end

    req = 4'b0011;
    tick();
`ifdef ARB_HOLD_LIMIT_EN
    chk_out("sat_preempt", 4'b0010, 2'd1, 1'b1);
`else
    chk_out("sat_preempt", 4'b0001, 2'd0, 1'b1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
